// File: rtl/imem_uart_loader.sv
// UART program loader: assembles framed bytes into 32-bit words, writes them to instruction RAM,
// and holds the CPU in reset until a checksum-verified image has been loaded.
module imem_uart_loader #(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned     TmoW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoLast  = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]     MaxWords = 17'(1) << ADDR_W;

  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StData,
    StCheck,
    StDone,
    StError
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          len_hi_q, len_hi_d;
  logic [15:0]         len_q, len_d;
  logic [31:0]         word_q, word_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [7:0]          csum_q, csum_d;
  logic [TmoW-1:0]     tmo_q, tmo_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [31:0]         wr_data_q, wr_data_d;
  logic [ADDR_W:0]     words_q, words_d;
  logic                hold_q, hold_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic                in_frame;
  logic                go_error;
  logic                last_word;
  logic [15:0]         len_rx;

  always_comb begin
    state_d    = state_q;
    len_hi_d   = len_hi_q;
    len_d      = len_q;
    word_d     = word_q;
    byte_idx_d = byte_idx_q;
    csum_d     = csum_q;
    tmo_d      = tmo_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    words_d    = words_q;
    hold_d     = hold_q;
    busy_d     = busy_q;
    done_d     = done_q;
    error_d    = error_q;
    go_error   = 1'b0;
    len_rx     = {len_hi_q, rx_data};
    last_word  = (32'(words_q) + 32'd1) == 32'(len_q);
    in_frame   = (state_q == StLenHi) || (state_q == StLenLo) ||
                 (state_q == StData)  || (state_q == StCheck);

    // start always wins: any byte on the same cycle and any word in flight are dropped
    if (start) begin
      state_d    = StLenHi;
      hold_d     = 1'b1;
      busy_d     = 1'b1;
      done_d     = 1'b0;
      error_d    = 1'b0;
      words_d    = '0;
      csum_d     = '0;
      byte_idx_d = '0;
      tmo_d      = '0;
    end else begin
      case (state_q)
        StLenHi: begin
          if (rx_valid) begin
            len_hi_d = rx_data;
            state_d  = StLenLo;
          end
        end
        StLenLo: begin
          if (rx_valid) begin
            len_d = len_rx;
            if (len_rx == 16'd0 || {1'b0, len_rx} > MaxWords) begin
              go_error = 1'b1;
            end else begin
              state_d = StData;
            end
          end
        end
        StData: begin
          if (rx_valid) begin
            csum_d     = csum_q ^ rx_data;
            byte_idx_d = byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              wr_en_d   = 1'b1;
              wr_addr_d = words_q[ADDR_W-1:0];
              wr_data_d = {rx_data, word_q[23:0]};
              words_d   = words_q + 1'b1;
              if (last_word) begin
                state_d = StCheck;
              end
            end else begin
              word_d[{byte_idx_q, 3'b000} +: 8] = rx_data;
            end
          end
        end
        StCheck: begin
          if (rx_valid) begin
            if (rx_data == csum_q) begin
              state_d = StDone;
              done_d  = 1'b1;
              hold_d  = 1'b0;
              busy_d  = 1'b0;
            end else begin
              go_error = 1'b1;
            end
          end
        end
        default: ;
      endcase

      if (in_frame) begin
        if (rx_valid) begin
          tmo_d = '0;
        end else if (tmo_q == TmoLast) begin
          go_error = 1'b1;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end

      // cpu_hold is left set: RAM contents are untrusted after a failed load
      if (go_error) begin
        state_d = StError;
        error_d = 1'b1;
        busy_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      len_hi_q   <= '0;
      len_q      <= '0;
      word_q     <= '0;
      byte_idx_q <= '0;
      csum_q     <= '0;
      tmo_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      words_q    <= '0;
      hold_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_hi_q   <= len_hi_d;
      len_q      <= len_d;
      word_q     <= word_d;
      byte_idx_q <= byte_idx_d;
      csum_q     <= csum_d;
      tmo_q      <= tmo_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      words_q    <= words_d;
      hold_q     <= hold_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign cpu_hold     = hold_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Bench for imem_uart_loader: table of directed frames, hand-written corner sequences and
// random frames checked against a whole-frame reference model.
module tb_imem_uart_loader;

  localparam int unsigned AW  = 8;
  localparam int unsigned TMO = 50;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          cpu_hold, busy, done, error;
  logic [AW:0]   words_loaded;

  int checks = 0;
  int errors = 0;

  logic [7:0]    fb[$];
  logic [31:0]   src_words[$];
  logic [31:0]   exp_words[$];
  logic [AW-1:0] cap_addr[$];
  logic [31:0]   cap_data[$];

  typedef struct {
    logic [15:0] n;
    bit          corrupt;
    int          gap;
    bit          e_done;
    bit          e_err;
    int          e_wl;
  } vec_t;

  vec_t vecs[6];

  imem_uart_loader #(
    .ADDR_W         (AW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      cap_addr.push_back(wr_addr);
      cap_data.push_back(wr_data);
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached (checks=%0d)", checks);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // All tasks are entered and left 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    idle(gap);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic fill_words(input logic [15:0] n);
    src_words.delete();
    if (n == 16'd3) begin
      src_words.push_back(32'h0800_000E);
      src_words.push_back(32'h0800_0034);
      src_words.push_back(32'h0800_0087);
    end else begin
      for (int i = 0; i < int'(n) && i < 256; i++) begin
        src_words.push_back(32'hA500_0000 ^ (i * 32'h0001_0203));
      end
    end
  endtask

  task automatic build_frame(input logic [15:0] n, input bit corrupt);
    logic [7:0]  x;
    logic [31:0] w;
    x = 8'h00;
    fb.delete();
    fb.push_back(n[15:8]);
    fb.push_back(n[7:0]);
    if (n == 16'd0 || n > 16'd256) return;
    for (int i = 0; i < int'(n); i++) begin
      w = src_words[i];
      for (int b = 0; b < 4; b++) begin
        fb.push_back(w[8*b +: 8]);
        x = x ^ w[8*b +: 8];
      end
    end
    fb.push_back(x ^ {7'b0, corrupt});
  endtask

  // Reference model: outcome of a complete frame computed from its byte list alone.
  task automatic model_frame(output bit e_done, output bit e_err, output int e_wl);
    int         n;
    logic [7:0] x;
    exp_words.delete();
    n      = int'({fb[0], fb[1]});
    e_done = 1'b0;
    e_err  = 1'b1;
    e_wl   = 0;
    if (n == 0 || n > (1 << AW)) return;
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      exp_words.push_back({fb[2+4*i+3], fb[2+4*i+2], fb[2+4*i+1], fb[2+4*i]});
    end
    for (int i = 2; i < 2 + 4 * n; i++) x = x ^ fb[i];
    e_wl   = n;
    e_done = (fb[2+4*n] == x);
    e_err  = !e_done;
  endtask

  task automatic send_frame_bytes(input int gap);
    int g;
    for (int i = 0; i < fb.size(); i++) begin
      if (i == fb.size() - 1 && fb.size() > 2) check("hold_before_last", cpu_hold, 1);
      g = (gap < 0) ? int'($urandom_range(3, 0)) : gap;
      send_byte(fb[i], (i == fb.size() - 1) ? 0 : g);
    end
  endtask

  task automatic run_frame(input int gap);
    cap_addr.delete();
    cap_data.delete();
    pulse_start();
    check("start_busy", busy, 1);
    check("start_hold", cpu_hold, 1);
    check("start_done_err", {done, error}, 0);
    check("start_words", words_loaded, 0);
    send_frame_bytes(gap);
  endtask

  // Sampled one cycle after the final byte of the frame.
  task automatic compare_result(input bit e_done, input bit e_err, input int e_wl);
    check("done", done, e_done);
    check("error", error, e_err);
    check("cpu_hold", cpu_hold, !e_done);
    check("busy", busy, 0);
    check("words_loaded", words_loaded, e_wl);
    idle(2);
    check("write_count", cap_addr.size(), exp_words.size());
    for (int i = 0; i < cap_addr.size() && i < exp_words.size(); i++) begin
      check("wr_addr", cap_addr[i], i);
      check("wr_data", cap_data[i], exp_words[i]);
    end
  endtask

  initial begin
    bit          m_done, m_err;
    int          m_wl;
    logic [15:0] n;
    int          r;

    vecs[0] = '{n: 16'd3,     corrupt: 1'b0, gap: 15, e_done: 1'b1, e_err: 1'b0, e_wl: 3};
    vecs[1] = '{n: 16'd3,     corrupt: 1'b1, gap: 15, e_done: 1'b0, e_err: 1'b1, e_wl: 3};
    vecs[2] = '{n: 16'h0000,  corrupt: 1'b0, gap: 2,  e_done: 1'b0, e_err: 1'b1, e_wl: 0};
    vecs[3] = '{n: 16'h0101,  corrupt: 1'b0, gap: 2,  e_done: 1'b0, e_err: 1'b1, e_wl: 0};
    vecs[4] = '{n: 16'd4,     corrupt: 1'b0, gap: 0,  e_done: 1'b1, e_err: 1'b0, e_wl: 4};
    vecs[5] = '{n: 16'h0100,  corrupt: 1'b0, gap: 0,  e_done: 1'b1, e_err: 1'b0, e_wl: 256};

    #2 reset = 1'b0;
    #1;
    check("reset_outputs", {wr_en, wr_addr, wr_data, cpu_hold, busy, done, error, words_loaded}, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    idle(2);
    check("idle_outputs", {wr_en, cpu_hold, busy, done, error, words_loaded}, 0);

    // Directed frames
    for (int v = 0; v < 6; v++) begin
      fill_words(vecs[v].n);
      build_frame(vecs[v].n, vecs[v].corrupt);
      exp_words.delete();
      for (int i = 0; i < vecs[v].e_wl; i++) exp_words.push_back(src_words[i]);
      run_frame(vecs[v].gap);
      compare_result(vecs[v].e_done, vecs[v].e_err, vecs[v].e_wl);
    end

    // Timeout: stop after the 6th byte of an N=3 frame
    fill_words(16'd3);
    build_frame(16'd3, 1'b0);
    cap_addr.delete();
    cap_data.delete();
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(fb[i], (i == 5) ? 0 : 1);
    idle(TMO - 1);
    check("tmo_not_yet", error, 0);
    idle(1);
    check("tmo_error", error, 1);
    check("tmo_words", words_loaded, 1);
    check("tmo_hold", cpu_hold, 1);
    check("tmo_busy", busy, 0);
    idle(2);
    check("tmo_writes", cap_addr.size(), 1);

    // Restart mid-DATA, with start colliding with the byte that would complete a word
    cap_addr.delete();
    cap_data.delete();
    pulse_start();
    send_byte(8'h00, 1);
    send_byte(8'h02, 1);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    send_byte(8'hCC, 0);
    start    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'hDD;
    @(posedge clk);
    #1;
    start    = 1'b0;
    rx_valid = 1'b0;
    check("restart_busy", busy, 1);
    check("restart_words", words_loaded, 0);
    src_words.delete();
    src_words.push_back(32'hCAFE_F00D);
    build_frame(16'd1, 1'b0);
    exp_words.delete();
    exp_words.push_back(32'hCAFE_F00D);
    send_frame_bytes(1);
    compare_result(1'b1, 1'b0, 1);

    // Asynchronous reset mid-DATA on the cycle of a 4th byte
    cap_addr.delete();
    cap_data.delete();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    rx_valid = 1'b1;
    rx_data  = 8'h44;
    reset    = 1'b0;
    #1;
    check("midreset_outputs",
          {wr_en, wr_addr, wr_data, cpu_hold, busy, done, error, words_loaded}, 0);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    reset    = 1'b1;
    idle(5);
    check("midreset_no_write", cap_addr.size(), 0);
    check("midreset_state", {cpu_hold, busy, done, error, words_loaded}, 0);

    // Random frames against the reference model
    for (int t = 0; t < 10; t++) begin
      r = int'($urandom_range(9, 0));
      if (r == 0) n = 16'd0;
      else if (r == 9) n = 16'(257 + $urandom_range(50, 0));
      else n = 16'(r);
      src_words.delete();
      for (int i = 0; i < r && r < 9; i++) src_words.push_back($urandom);
      build_frame(n, ($urandom_range(3, 0) == 0));
      model_frame(m_done, m_err, m_wl);
      run_frame(-1);
      compare_result(m_done, m_err, m_wl);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
